// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/LSU request ports, RAM port and protection/status bundle
interface mem_port_arbiter_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int CntWidth  = 16
);
    logic                   instr_req_i;
    logic [AddrWidth-1:0]   instr_addr_i;
    logic                   instr_gnt_o;
    logic                   instr_rvalid_o;
    logic                   instr_err_o;
    logic [DataWidth-1:0]   instr_rdata_o;

    logic                   data_req_i;
    logic                   data_we_i;
    logic [DataWidth/8-1:0] data_be_i;
    logic [AddrWidth-1:0]   data_addr_i;
    logic [DataWidth-1:0]   data_wdata_i;
    logic                   data_gnt_o;
    logic                   data_rvalid_o;
    logic                   data_err_o;
    logic [DataWidth-1:0]   data_rdata_o;

    logic                   mem_req_o;
    logic                   mem_we_o;
    logic [DataWidth/8-1:0] mem_be_o;
    logic [AddrWidth-1:0]   mem_addr_o;
    logic [DataWidth-1:0]   mem_wdata_o;
    logic                   mem_rvalid_i;
    logic [DataWidth-1:0]   mem_rdata_i;

    logic                   prot_en_i;
    logic [AddrWidth-1:0]   prot_base_i;
    logic [AddrWidth-1:0]   prot_limit_i;
    logic [CntWidth-1:0]    viol_count_o;
    logic [AddrWidth-1:0]   viol_addr_o;
    logic                   proto_err_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rvalid_i, mem_rdata_i,
        input  prot_en_i, prot_base_i, prot_limit_i,
        output viol_count_o, viol_addr_o, proto_err_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rvalid_i, mem_rdata_i,
        output prot_en_i, prot_base_i, prot_limit_i,
        input  viol_count_o, viol_addr_o, proto_err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch/LSU) arbiter onto a single-port RAM with write protection
module mem_port_arbiter #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int CntWidth  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {RESP_NONE, RESP_INSTR, RESP_DATA, RESP_ERR} resp_e;
    typedef enum logic {PRIO_INSTR, PRIO_DATA} prio_e;

    resp_e                resp_q, resp_d;
    prio_e                prio_q, prio_d;
    logic [CntWidth-1:0]  viol_count_q;
    logic [AddrWidth-1:0] viol_addr_q;
    logic                 proto_err_q;
    logic                 drop_q;

    logic gnt_instr, gnt_data, in_range, blocked, stray;

    always_comb begin
        gnt_data  = 1'b0;
        gnt_instr = 1'b0;
        in_range  = 1'b0;
        blocked   = 1'b0;
        resp_d    = RESP_NONE;
        prio_d    = prio_q;

        gnt_data  = rst_ni && bus.data_req_i && (!bus.instr_req_i || prio_q == PRIO_DATA);
        gnt_instr = rst_ni && bus.instr_req_i && !gnt_data;
        // A base above the limit yields no match, i.e. an empty range.
        in_range  = (bus.data_addr_i >= bus.prot_base_i) && (bus.data_addr_i <= bus.prot_limit_i);
        blocked   = gnt_data && bus.data_we_i && bus.prot_en_i && in_range;

        if (gnt_instr) begin
            resp_d = RESP_INSTR;
        end else if (blocked) begin
            resp_d = RESP_ERR;
        end else if (gnt_data) begin
            resp_d = RESP_DATA;
        end

        if (rst_ni && bus.instr_req_i && bus.data_req_i) begin
            prio_d = (prio_q == PRIO_DATA) ? PRIO_INSTR : PRIO_DATA;
        end
    end

    always_comb begin
        bus.instr_gnt_o = gnt_instr;
        bus.data_gnt_o  = gnt_data;
        bus.mem_req_o   = gnt_instr || (gnt_data && !blocked);
        bus.mem_we_o    = gnt_data && bus.data_we_i;
        bus.mem_be_o    = '0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (gnt_instr) begin
            bus.mem_be_o   = '1;
            bus.mem_addr_o = bus.instr_addr_i;
        end else if (gnt_data) begin
            bus.mem_be_o    = bus.data_be_i;
            bus.mem_addr_o  = bus.data_addr_i;
            bus.mem_wdata_o = bus.data_wdata_i;
        end
    end

    // Responses are suppressed while reset is low so an in-flight one is lost.
    always_comb begin
        bus.instr_rvalid_o = rst_ni && (resp_q == RESP_INSTR) && bus.mem_rvalid_i;
        bus.instr_rdata_o  = (resp_q == RESP_INSTR) ? bus.mem_rdata_i : '0;
        bus.instr_err_o    = 1'b0;
        bus.data_rvalid_o  = rst_ni && (((resp_q == RESP_DATA) && bus.mem_rvalid_i) ||
                                        (resp_q == RESP_ERR));
        bus.data_rdata_o   = (resp_q == RESP_DATA) ? bus.mem_rdata_i : '0;
        bus.data_err_o     = rst_ni && (resp_q == RESP_ERR);
        bus.viol_count_o   = viol_count_q;
        bus.viol_addr_o    = viol_addr_q;
        bus.proto_err_o    = proto_err_q;
    end

    // drop_q covers a RAM response still in flight across the reset edge.
    assign stray = bus.mem_rvalid_i && !drop_q &&
                   ((resp_q == RESP_NONE) || (resp_q == RESP_ERR));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_q       <= RESP_NONE;
            prio_q       <= PRIO_DATA;
            viol_count_q <= '0;
            viol_addr_q  <= '0;
            proto_err_q  <= 1'b0;
            drop_q       <= 1'b1;
        end else begin
            resp_q <= resp_d;
            prio_q <= prio_d;
            drop_q <= 1'b0;
            if (blocked) begin
                viol_addr_q <= bus.data_addr_i;
                if (viol_count_q != '1) begin
                    viol_count_q <= viol_count_q + 1'b1;
                end
            end
            if (stray) begin
                proto_err_q <= 1'b1;
            end
        end
    end
endmodule
